uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte FIFO sitting directly upstream of TX_SEND. It decouples a bursty byte producer (command responder, message sequencer) from the UART transmitter's one-byte-at-a-time rdy/wen handshake. It drives TX_SEND's wen/din from its head entry whenever TX_SEND reports rdy and the FIFO holds data. It also provides full/empty/level status and a sticky overflow flag to the producer.

Parameters:
DW, 8, data width in bits; must match TX_SEND's DW.
AW, 4, address width; depth = 2**AW entries (16 by default).

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
wr_en  in  1  producer write strobe; one byte per cycle when high.
wr_data  in  DW  producer byte, sampled when wr_en=1.
full  out  1  high when level == 2**AW.
empty  out  1  high when level == 0.
level  out  AW+1  current number of stored bytes, 0..2**AW.
overflow  out  1  sticky; set by a write attempted while full.
flush  in  1  synchronous clear of contents; does not clear overflow.
tx_rdy  in  1  connected to TX_SEND rdy.
tx_wen  out  1  connected to TX_SEND wen.
tx_din  out  DW  connected to TX_SEND din.

Behaviour:
- Reset is synchronous and active-high on CLK: RST=1 sampled at a rising edge clears rd_ptr, wr_ptr, level and overflow.
- Output values after reset: full=0, empty=1, level=0, overflow=0, tx_wen=0. tx_din is don't-care but must not be X-driven from reset logic.
- Storage: 2**AW x DW register array with asynchronous read of entry rd_ptr (show-ahead). Pointers are AW bits and wrap naturally from 2**AW-1 to 0. level is a separate AW+1-bit counter.
- Push = wr_en & ~full. The byte is written at wr_ptr and wr_ptr increments.
- wr_en & full: the byte is dropped, pointers are unchanged, and overflow is set at that edge.
- Pop = tx_wen = tx_rdy & ~empty, purely combinational. tx_din = mem[rd_ptr], valid whenever ~empty. rd_ptr increments at the same edge TX_SEND samples din.
- Level update: push only +1; pop only -1; push and pop together leaves level unchanged.
  - Simultaneous push and pop is legal at any level except full, where only the pop proceeds (no push while full, even if a pop frees a slot in the same cycle).
  - At empty, only the push proceeds.
- No fall-through: a byte written into an empty FIFO raises tx_wen no earlier than the next cycle. Minimum wr_en-to-tx_wen latency is 1 cycle.
- flush=1 clears pointers and level at the edge and overrides push/pop in that cycle. The consequences:
  - tx_wen is forced low during flush.
  - A wr_en in the flush cycle is discarded.
  - overflow is left untouched.
- RST has priority over flush, push and pop. RST asserted mid-burst discards all contents; TX_SEND sees tx_wen=0 from the reset cycle onward.
- full, empty and overflow are decoded from registered state, with no combinational path from wr_en. tx_wen has a combinational path from tx_rdy only.

Decomposition:
- Shared package uart_pkg holds:
  - DW default (8);
  - ASCII constants CHAR_CR=8'h0d and CHAR_LF=8'h0a, used by benches and future line-oriented blocks.
- One natural sub-module: uart_fifo_mem, the 2**AW x DW array with a write port and an asynchronous read port. It is reusable for the receive-side line buffer.
- Pointer, level and handshake control stay in uart_tx_fifo.

Test Plan:
- Reset and empty: hold RST=1 for 3 cycles with tx_rdy=1, then release -> empty=1, full=0, level=0, overflow=0, tx_wen=0 on every cycle.
- Message ordering: with tx_rdy=0, write 8'h56,8'h45,8'h52,8'h0d,8'h0a on consecutive cycles -> level=5. Then drive a TX_SEND-like rdy model -> tx_din sequence on tx_wen pulses is 56,45,52,0d,0a; afterwards empty=1.
- Fill, overflow and wrap:
  - Write 16 bytes 8'h00..8'h0f -> full=1, level=16.
  - Write 8'hff -> dropped, overflow=1.
  - Drain 16 -> data 00..0f.
  - Write 20 more with concurrent draining -> pointers wrap with no data loss or duplication.
- Simultaneous push/pop:
  - At level=3, drive wr_en=1 and tx_rdy=1 together for 10 cycles -> level stays 3 and output order is preserved.
  - At full, the same stimulus -> level drops to 15 and the write is dropped with overflow set.
- Flush: at level=7 assert flush with wr_en=1 -> next cycle level=0, empty=1, tx_wen=0, overflow unchanged; the written byte never appears at tx_din.
- End-to-end: instantiate uart_tx_fifo -> TX_SEND -> RX_RECV and burst "VER\r\n" in 5 cycles -> RX_RECV emits valid with dot=56,45,52,0d,0a in order and no drops.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width and line-control characters.
package uart_pkg;

  localparam int unsigned UART_DW = 8;

  localparam logic [7:0] CHAR_CR = 8'h0d;
  localparam logic [7:0] CHAR_LF = 8'h0a;

endpackage

// File: rtl/uart_fifo_mem.sv
// 2**AW x DW register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DW = UART_DW,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding TX_SEND's rdy/wen handshake, with level and
// sticky overflow status for the producer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DW = UART_DW,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          flush,
  input  logic          tx_rdy,
  output logic          tx_wen,
  output logic [DW-1:0] tx_din
);

  localparam logic [AW:0] L_DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_level == L_DEPTH);
  assign w_empty = (r_level == '0);

  // Full blocks the write even when a pop frees a slot in the same cycle.
  assign w_push = wr_en & ~w_full & ~flush & ~RST;
  assign w_pop  = tx_rdy & ~w_empty & ~flush & ~RST;
  assign w_drop = wr_en & w_full & ~flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_level <= r_level + 1'b1;
        end else if (!w_push && w_pop) begin
          r_level <= r_level - 1'b1;
        end
      end
    end
  end

  uart_fifo_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .CLK    (CLK),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata(wr_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(tx_din)
  );

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign tx_wen   = w_pop;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// plus literal expectations on levels, flags and delivered byte sequences.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_rdy = 1'b1;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_wen;
  logic [7:0] tx_din;

  uart_tx_fifo #(
    .DW(8),
    .AW(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .flush   (flush),
    .tx_rdy  (tx_rdy),
    .tx_wen  (tx_wen),
    .tx_din  (tx_din)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] obs[$];
  bit         m_ovf = 1'b0;
  bit         started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue updated from the inputs seen at each edge.
  initial begin
    forever begin
      @(posedge CLK);
      started = 1'b1;
      if (RST) begin
        mq.delete();
        m_ovf = 1'b0;
      end else if (flush) begin
        mq.delete();
      end else begin
        bit do_pop;
        bit do_push;
        do_pop  = tx_rdy && (mq.size() > 0);
        do_push = wr_en && (mq.size() < DEPTH);
        if (wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(wr_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (started) begin
        int  n;
        bit  e_wen;
        n     = mq.size();
        e_wen = !RST && !flush && tx_rdy && (n > 0);
        chk("level", int'(level), n);
        chk("full", int'(full), int'(n == DEPTH));
        chk("empty", int'(empty), int'(n == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tx_wen", int'(tx_wen), int'(e_wen));
        if (e_wen) chk("tx_din", int'(tx_din), int'(mq[0]));
        if (tx_wen === 1'b1) obs.push_back(tx_din);
      end
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en   = w;
    wr_data = d;
    tx_rdy  = r;
    flush   = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int maxc, input bit alt);
    int n;
    n = 0;
    while (mq.size() > 0 && n < maxc) begin
      cyc(1'b0, 8'h00, alt ? (n % 2 == 0) : 1'b1, 1'b0);
      n++;
    end
    if (mq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles", mq.size(), maxc);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_obs(input string nm, input logic [7:0] e[$]);
    chk({nm, "_count"}, obs.size(), e.size());
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      chk(nm, int'(obs[i]), int'(e[i]));
    end
    obs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e[$];

    // Reset held 3 cycles with tx_rdy high.
    RST = 1'b1;
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    RST = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_wen", int'(tx_wen), 0);

    // Message ordering.
    obs.delete();
    cyc(1'b1, 8'h56, 1'b0, 1'b0);
    cyc(1'b1, 8'h45, 1'b0, 1'b0);
    cyc(1'b1, 8'h52, 1'b0, 1'b0);
    cyc(1'b1, CHAR_CR, 1'b0, 1'b0);
    cyc(1'b1, CHAR_LF, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("msg_level", int'(level), 5);
    drain(40, 1'b1);
    e = '{8'h56, 8'h45, 8'h52, 8'h0d, 8'h0a};
    chk_obs("msg_seq", e);
    chk("msg_empty", int'(empty), 1);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    cyc(1'b1, 8'hff, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(level), 16);
    drain(40, 1'b0);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(8'(i));
    chk_obs("fill_seq", e);

    // Wrap with concurrent draining.
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h20 + i), (i % 2 == 0), 1'b0);
    drain(60, 1'b0);
    e.delete();
    for (int i = 0; i < 20; i++) e.push_back(8'(8'h20 + i));
    chk_obs("wrap_seq", e);

    // Simultaneous push/pop at level 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'ha0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hb0 + i), 1'b1, 1'b0);
    wr_en  = 1'b0;
    tx_rdy = 1'b0;
    #1;
    chk("simul_level", int'(level), 3);
    drain(40, 1'b0);
    e.delete();
    for (int i = 0; i < 3; i++) e.push_back(8'(8'ha0 + i));
    for (int i = 0; i < 10; i++) e.push_back(8'(8'hb0 + i));
    chk_obs("simul_seq", e);

    // Push/pop at full: only the pop proceeds.
    RST = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    RST = 1'b0;
    chk("rst2_ovf", int'(overflow), 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hc0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hd0, 1'b1, 1'b0);
    chk("full_pp_level", int'(level), 15);
    chk("full_pp_ovf", int'(overflow), 1);
    drain(40, 1'b0);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(8'(8'hc0 + i));
    chk_obs("full_pp_seq", e);

    // Flush at level 7 with a concurrent write.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'he0 + i), 1'b0, 1'b0);
    chk("flush_pre_level", int'(level), 7);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_level", int'(level), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovf", int'(overflow), 1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    e.delete();
    chk_obs("flush_seq", e);

    // Reset mid-burst: tx_wen drops in the reset cycle.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hf0 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    RST = 1'b1;
    #1;
    chk("rst_burst_wen", int'(tx_wen), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    RST = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_burst_empty", int'(empty), 1);
    chk("rst_burst_ovf", int'(overflow), 0);
    e = '{8'hf0};
    chk_obs("rst_burst_seq", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
